// File: rtl/pipe_pkg.sv
// Shared encodings and defaults for the D->E stall controller and its mult/div busy tracker.
package pipe_pkg;

  localparam logic [1:0] TUSE_NONE       = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;
  localparam int         CNT_W_DEF       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Read-after-write hit for one source operand against one producer stage.
  // A producer whose result is ready no later than the consumer needs it is forwarded, not stalled.
  function automatic logic hazard_hit(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_fsm.sv
// Mult/div occupancy tracker: counts the fixed busy period after issue and pulses done on completion.
module md_busy_fsm
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_div_E,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // NOTE: state and outputs are all flops updated with <= so every read in this block sees
  // the pre-edge value; a blocking assignment here would leak the new value into later lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (md_start_E) begin
            r_cnt   <= md_div_E ? DIV_LOAD : MULT_LOAD;
            r_state <= BUSY;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          // A late md_start_E here is ignored: the issuing instruction is still held in D.
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= (r_cnt == CNT_W'(1));
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = r_busy;
  assign md_done = r_done;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Decode-stage hazard controller: freezes F/D and bubbles E on RAW or mult/div hazards.
// Define STALL_STATS_EN to build the 32-bit cumulative stall counter; otherwise stall_cnt is 0.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  a_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  a_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  output logic        stall,
  output logic        clr_E,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_md_busy;
  logic w_stall;

  assign w_stall_rs = hazard_hit(rs_D, tuse_rs_D, a_E, tnew_E) |
                      hazard_hit(rs_D, tuse_rs_D, a_M, tnew_M);
  assign w_stall_rt = hazard_hit(rt_D, tuse_rt_D, a_E, tnew_E) |
                      hazard_hit(rt_D, tuse_rt_D, a_M, tnew_M);

  // The issue cycle itself must hold any HI/LO user in D, before md_busy has risen.
  assign w_stall_md = md_use_D & (md_start_E | w_md_busy);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_fsm (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_busy    (w_md_busy),
    .md_done    (md_done)
  );

  assign stall   = w_stall;
  assign clr_E   = w_stall;
  assign md_busy = w_md_busy;

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vectors plus a cycle-level reference model.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_D = '0, rt_D = '0, a_E = '0, a_M = '0;
  logic [1:0]  tuse_rs_D = 2'd3, tuse_rt_D = 2'd3, tnew_E = '0, tnew_M = '0;
  logic        md_start_E = 1'b0, md_div_E = 1'b0, md_use_D = 1'b0;
  logic        stall, clr_E, md_busy, md_done;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pipe_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .a_E        (a_E),
    .tnew_E     (tnew_E),
    .a_M        (a_M),
    .tnew_M     (tnew_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .clr_E      (clr_E),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mult/div occupancy is tracked as an issue edge number plus a length,
  // so busy means "fewer than N edges since issue" and done is the edge count exactly N.
  int          k        = 0;
  int          m_issue  = 0;
  int          m_len    = 0;
  bit          m_active = 1'b0;
  logic [31:0] m_cnt    = '0;
  bit          chk_en   = 1'b0;

  function automatic bit exp_busy();
    return m_active && (k < m_issue + m_len);
  endfunction

  function automatic bit exp_done();
    return m_active && (k == m_issue + m_len);
  endfunction

  function automatic bit raw(input int src, input int tuse, input int dst, input int tnew);
    return (src != 0) && (src == dst) && (tuse != 3) && (tuse < tnew);
  endfunction

  function automatic bit exp_stall();
    bit r;
    r = raw(rs_D, tuse_rs_D, a_E, tnew_E) || raw(rs_D, tuse_rs_D, a_M, tnew_M) ||
        raw(rt_D, tuse_rt_D, a_E, tnew_E) || raw(rt_D, tuse_rt_D, a_M, tnew_M);
    return r || (md_use_D && (md_start_E || exp_busy()));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_cnt    = '0;
    end else begin
      bit was_busy;
      was_busy = exp_busy();
      if (exp_stall()) m_cnt = m_cnt + 32'd1;
      k++;
      if (md_start_E && !was_busy) begin
        m_active = 1'b1;
        m_issue  = k;
        m_len    = md_div_E ? 10 : 5;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_stall", {31'd0, stall}, {31'd0, exp_stall()});
      check("model_clr_E", {31'd0, clr_E}, {31'd0, exp_stall()});
      check("model_md_busy", {31'd0, md_busy}, {31'd0, exp_busy()});
      check("model_md_done", {31'd0, md_done}, {31'd0, exp_done()});
`ifdef STALL_STATS_EN
      check("model_stall_cnt", stall_cnt, m_cnt);
`else
      check("model_stall_cnt", stall_cnt, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    a_E = '0; tnew_E = '0; a_M = '0; tnew_M = '0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_md_busy", {31'd0, md_busy}, 32'd0);
    check("reset_md_done", {31'd0, md_done}, 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    tick();
    #2 reset = 1'b0;
  endtask

  int nb, nd;

  initial begin
    quiet();
    #2;
    check("por_md_busy", {31'd0, md_busy}, 32'd0);
    check("por_md_done", {31'd0, md_done}, 32'd0);
    check("por_stall_cnt", stall_cnt, 32'd0);
    check("por_stall", {31'd0, stall}, 32'd0);
    tick(); tick();
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick();

    // RAW on rs: E producer, then M producer, then M result ready.
    rs_D = 5'd8; tuse_rs_D = 2'd0; a_E = 5'd8; tnew_E = 2'd2;
    #1;
    check("rs_E_stall", {31'd0, stall}, 32'd1);
    check("rs_E_clr", {31'd0, clr_E}, 32'd1);
    tick();
    a_E = 5'd0; tnew_E = 2'd0; a_M = 5'd8; tnew_M = 2'd1;
    #1 check("rs_M_stall", {31'd0, stall}, 32'd1);
    tick();
    tnew_M = 2'd0;
    #1 check("rs_M_ready", {31'd0, stall}, 32'd0);
    tick();

    // Register 0 never stalls, tuse=3 never stalls, tuse==tnew forwards.
    quiet();
    rs_D = 5'd0; a_E = 5'd0; tnew_E = 2'd2; tuse_rs_D = 2'd0;
    #1 check("r0_no_stall", {31'd0, stall}, 32'd0);
    tick();
    quiet();
    rt_D = 5'd9; tuse_rt_D = 2'd3; a_E = 5'd9; tnew_E = 2'd2;
    #1 check("tuse3_no_stall", {31'd0, stall}, 32'd0);
    tick();
    tuse_rt_D = 2'd2;
    #1 check("tuse_eq_tnew", {31'd0, stall}, 32'd0);
    tick();
    tuse_rt_D = 2'd1;
    #1 check("rt_E_stall", {31'd0, stall}, 32'd1);
    tick();

    // Mult issue with a HI/LO user held in D.
    quiet();
    md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
    #1 check("mult_issue_stall", {31'd0, stall}, 32'd1);
    tick();
    md_start_E = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("mult_busy", {31'd0, md_busy}, 32'd1);
      check("mult_busy_stall", {31'd0, stall}, 32'd1);
      check("mult_no_done", {31'd0, md_done}, 32'd0);
      tick();
    end
    check("mult_done_busy", {31'd0, md_busy}, 32'd0);
    check("mult_done_pulse", {31'd0, md_done}, 32'd1);
    check("mult_done_stall", {31'd0, stall}, 32'd0);
    tick();
    check("mult_done_once", {31'd0, md_done}, 32'd0);

    // Full div: busy exactly 10 cycles, one done pulse.
    quiet();
    md_start_E = 1'b1; md_div_E = 1'b1;
    tick();
    quiet();
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (md_busy) nb++;
      if (md_done) nd++;
      tick();
    end
    check("div_busy_len", nb, 32'd10);
    check("div_done_cnt", nd, 32'd1);

    // Div abandoned by async reset at busy cycle 4.
    md_start_E = 1'b1; md_div_E = 1'b1;
    tick();
    quiet();
    tick(); tick(); tick();
    check("div_cycle4_busy", {31'd0, md_busy}, 32'd1);
    pulse_reset();
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (md_done) nd++;
      tick();
    end
    check("div_abort_no_done", nd, 32'd0);

    // Issue alongside an rt hazard; a stray start while busy must not reload.
    quiet();
    md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
    rt_D = 5'd5; tuse_rt_D = 2'd1; a_E = 5'd5; tnew_E = 2'd2;
    #1 check("simul_stall", {31'd0, stall}, 32'd1);
    tick();
    quiet();
    md_use_D = 1'b1;
    check("simul_busy", {31'd0, md_busy}, 32'd1);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      md_start_E = (i == 1); md_div_E = (i == 1);
      #1;
      if (md_busy && stall) nb++;
      tick();
    end
    check("simul_stall_len", nb, 32'd5);

    // Stall statistics: exactly 7 stalled edges since reset.
    quiet();
    pulse_reset();
    tick();
    rs_D = 5'd3; tuse_rs_D = 2'd0; a_M = 5'd3; tnew_M = 2'd1;
    for (int i = 0; i < 7; i++) tick();
    quiet();
    tick();
`ifdef STALL_STATS_EN
    check("stall_cnt_7", stall_cnt, 32'd7);
`else
    check("stall_cnt_off", stall_cnt, 32'd0);
`endif
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
